// File: rtl/twiddle9_rotator_pkg.sv
// Shared constants and arithmetic helpers for the DFT twiddle multipliers.
package twiddle9_rotator_pkg;

    localparam int WIDTH  = 18;   // sample and twiddle word width
    localparam int FRAC   = 10;   // twiddle fractional bits (1.0 = 1024)
    localparam int RADIX  = 9;    // points per group in this stage
    localparam int ADDR_W = 4;    // enough bits to address RADIX twiddles

    typedef logic [ADDR_W-1:0] tw_addr_t;

    // Round half-up at bit 'shift', then clip into a signed 'width'-bit range.
    function automatic longint round_sat(input longint value, input int shift, input int width);
        longint r;
        longint hi;
        longint lo;
        if (shift > 0) begin
            r = (value + (longint'(1) <<< (shift - 1))) >>> shift;
        end else begin
            r = value;
        end
        hi = (longint'(1) <<< (width - 1)) - 1;
        lo = -(longint'(1) <<< (width - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

    // Steps beyond the last twiddle index are pinned to RADIX-1.
    function automatic tw_addr_t clamp_step(input tw_addr_t step);
        return (step > tw_addr_t'(RADIX - 1)) ? tw_addr_t'(RADIX - 1) : step;
    endfunction

    // (a + b) mod RADIX for a, b < RADIX: one compare and one subtract.
    function automatic tw_addr_t add_mod_radix(input tw_addr_t a, input tw_addr_t b);
        logic [ADDR_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (ADDR_W + 1)'(RADIX)) begin
            sum = sum - (ADDR_W + 1)'(RADIX);
        end
        return sum[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/twiddle9_rotator_cmul_q.sv
// Two-stage complex multiply by a fixed-point coefficient with round/saturate.
// Stage 1 registers the four partial products; stage 2 combines, rounds and clips.
module cmul_q
    import twiddle9_rotator_pkg::*;
#(
    parameter int DATA_W = WIDTH,
    parameter int COEF_W = WIDTH,
    parameter int SHIFT  = FRAC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic signed [COEF_W-1:0] coef_re,
    input  logic signed [COEF_W-1:0] coef_im,
    output logic                     out_vld,
    output logic                     out_sof,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 1;

    logic signed [PROD_W-1:0] ac_p1_d, bd_p1_d, ad_p1_d, bc_p1_d;
    logic signed [PROD_W-1:0] ac_p1_q, bd_p1_q, ad_p1_q, bc_p1_q;
    logic                     vld_p1_d, sof_p1_d, vld_p1_q, sof_p1_q;
    logic signed [SUM_W-1:0]  re_sum_p1, im_sum_p1;
    logic                     vld_p2_d, sof_p2_d, vld_p2_q, sof_p2_q;
    logic signed [DATA_W-1:0] re_p2_d, im_p2_d, re_p2_q, im_p2_q;

    // Stage 1: the four full-width partial products of (a+jb)(c+jd)
    always_comb begin
        ac_p1_d  = PROD_W'(in_re) * PROD_W'(coef_re);
        bd_p1_d  = PROD_W'(in_im) * PROD_W'(coef_im);
        ad_p1_d  = PROD_W'(in_re) * PROD_W'(coef_im);
        bc_p1_d  = PROD_W'(in_im) * PROD_W'(coef_re);
        vld_p1_d = in_vld;
        sof_p1_d = in_vld & in_sof;
    end

    // Stage 2: combine at one guard bit, round and saturate; hold output when idle
    always_comb begin
        re_sum_p1 = SUM_W'(ac_p1_q) - SUM_W'(bd_p1_q);
        im_sum_p1 = SUM_W'(ad_p1_q) + SUM_W'(bc_p1_q);
        vld_p2_d  = vld_p1_q;
        sof_p2_d  = sof_p1_q;
        re_p2_d   = re_p2_q;
        im_p2_d   = im_p2_q;
        if (vld_p1_q) begin
            re_p2_d = DATA_W'(round_sat(longint'(re_sum_p1), SHIFT, DATA_W));
            im_p2_d = DATA_W'(round_sat(longint'(im_sum_p1), SHIFT, DATA_W));
        end
    end

    // Valids, markers and outputs clear on reset so nothing stale escapes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            sof_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            sof_p2_q <= 1'b0;
            re_p2_q  <= '0;
            im_p2_q  <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            sof_p1_q <= sof_p1_d;
            vld_p2_q <= vld_p2_d;
            sof_p2_q <= sof_p2_d;
            re_p2_q  <= re_p2_d;
            im_p2_q  <= im_p2_d;
        end
    end

    // Product registers are pure data and are qualified by vld_p1_q downstream
    always_ff @(posedge clk) begin
        ac_p1_q <= ac_p1_d;
        bd_p1_q <= bd_p1_d;
        ad_p1_q <= ad_p1_d;
        bc_p1_q <= bc_p1_d;
    end

    assign out_vld = vld_p2_q;
    assign out_sof = sof_p2_q;
    assign out_re  = re_p2_q;
    assign out_im  = im_p2_q;

endmodule

// File: rtl/twiddle9_rotator.sv
// Radix-9 twiddle rotator: walks the twiddle ROM address as (k*step) mod 9
// across each 9-sample group and rotates every sample by the returned twiddle.
module twiddle9_rotator
    import twiddle9_rotator_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    di_en,
    input  logic                    di_sof,
    input  logic [ADDR_W-1:0]       di_step,
    input  logic signed [WIDTH-1:0] di_re,
    input  logic signed [WIDTH-1:0] di_im,
    output logic [ADDR_W-1:0]       tw_addr,
    input  logic signed [WIDTH-1:0] tw_re,
    input  logic signed [WIDTH-1:0] tw_im,
    output logic                    do_en,
    output logic                    do_sof,
    output logic signed [WIDTH-1:0] do_re,
    output logic signed [WIDTH-1:0] do_im
);

    tw_addr_t k_q, k_d;
    tw_addr_t acc_q, acc_d;
    tw_addr_t step_q, step_d;
    tw_addr_t step_cur;
    tw_addr_t addr_cur;
    logic     group_start;

    // Current sample's address: a new group (explicit sof or counter at 0) starts at 0
    always_comb begin
        group_start = (di_en && di_sof) || (k_q == '0);
        addr_cur    = group_start ? '0 : acc_q;
        step_cur    = group_start ? clamp_step(di_step) : step_q;
    end

    assign tw_addr = addr_cur;

    // Advance counter and accumulator only on accepted samples; gaps hold state
    always_comb begin
        k_d    = k_q;
        acc_d  = acc_q;
        step_d = step_q;
        if (di_en) begin
            if (group_start) begin
                k_d = tw_addr_t'(1);
            end else if (k_q == tw_addr_t'(RADIX - 1)) begin
                k_d = '0;
            end else begin
                k_d = k_q + tw_addr_t'(1);
            end
            acc_d  = add_mod_radix(addr_cur, step_cur);
            step_d = step_cur;
        end
    end

    // Group state; reset makes the next accepted sample the start of a group
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q    <= '0;
            acc_q  <= '0;
            step_q <= '0;
        end else begin
            k_q    <= k_d;
            acc_q  <= acc_d;
            step_q <= step_d;
        end
    end

    cmul_q #(
        .DATA_W (WIDTH),
        .COEF_W (WIDTH),
        .SHIFT  (FRAC)
    ) u_cmul (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (di_en),
        .in_sof  (group_start),
        .in_re   (di_re),
        .in_im   (di_im),
        .coef_re (tw_re),
        .coef_im (tw_im),
        .out_vld (do_en),
        .out_sof (do_sof),
        .out_re  (do_re),
        .out_im  (do_im)
    );

endmodule

// File: tb/tb_twiddle9_rotator.sv
// Scoreboard bench for twiddle9_rotator with a behavioural group/rotation model.
module tb_twiddle9_rotator;

    localparam int W = 18;

    logic                clk = 1'b0;
    logic                rst;
    logic                di_en, di_sof;
    logic [3:0]          di_step;
    logic signed [W-1:0] di_re, di_im;
    logic [3:0]          tw_addr;
    logic signed [W-1:0] tw_re, tw_im;
    logic                do_en, do_sof;
    logic signed [W-1:0] do_re, do_im;

    twiddle9_rotator dut (
        .clk     (clk),
        .rst     (rst),
        .di_en   (di_en),
        .di_sof  (di_sof),
        .di_step (di_step),
        .di_re   (di_re),
        .di_im   (di_im),
        .tw_addr (tw_addr),
        .tw_re   (tw_re),
        .tw_im   (tw_im),
        .do_en   (do_en),
        .do_sof  (do_sof),
        .do_re   (do_re),
        .do_im   (do_im)
    );

    always #5 clk = ~clk;

    // Twiddle9 table: floor(1024*cos(2*pi*n/9)) + j*floor(-1024*sin(2*pi*n/9))
    int rom_re [9] = '{1024, 784, 177, -512, -963, -963, -512, 177, 784};
    int rom_im [9] = '{0, -659, -1009, -887, -351, 350, 886, 1008, 658};

    always_comb begin
        if (tw_addr < 4'd9) begin
            tw_re = W'(rom_re[tw_addr]);
            tw_im = W'(rom_im[tw_addr]);
        end else begin
            tw_re = '0;
            tw_im = '0;
        end
    end

    typedef struct {
        longint re;
        longint im;
        longint sof;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     model_k = 0;
    int     model_step = 0;
    longint last_re = 0;
    longint last_im = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round half-up by 1024 then clip to the 18-bit signed range
    function automatic longint rsat(input longint x);
        longint r;
        r = (x + 512) >>> 10;
        if (r > 131071) r = 131071;
        if (r < -131072) r = -131072;
        return r;
    endfunction

    // Present one sample, check its ROM address, and queue the expected output
    task automatic send(input bit sof, input int step, input int re, input int im);
        int   addr;
        exp_t e;
        @(negedge clk);
        di_en   = 1'b1;
        di_sof  = sof;
        di_step = 4'(step);
        di_re   = W'(re);
        di_im   = W'(im);
        if (sof || model_k == 0) begin
            model_k    = 0;
            model_step = (step > 8) ? 8 : step;
        end
        addr = (model_k * model_step) % 9;
        #1;
        chk("tw_addr", longint'(tw_addr), longint'(addr));
        e.re  = rsat(longint'(re) * rom_re[addr] - longint'(im) * rom_im[addr]);
        e.im  = rsat(longint'(re) * rom_im[addr] + longint'(im) * rom_re[addr]);
        e.sof = (model_k == 0) ? 1 : 0;
        e.cyc = cyc + 2;
        sb.push_back(e);
        model_k = (model_k + 1) % 9;
    endtask

    // Idle cycles with junk on the data/sof/step lines
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            di_en   = 1'b0;
            di_sof  = 1'($urandom);
            di_step = 4'($urandom);
            di_re   = W'($urandom);
            di_im   = W'($urandom);
        end
    endtask

    function automatic int rnd_data();
        return int'($urandom_range(262143, 0)) - 131072;
    endfunction

    // A full group: first sample carries the step, later ones carry a junk step
    task automatic group(input int step, input int re, input int im);
        send(1'b1, step, re, im);
        for (int i = 1; i < 9; i++) send(1'b0, int'($urandom_range(15, 0)), re, im);
    endtask

    // Assert reset while a sample is presented and another sits in stage 1
    task automatic reset_mid(input int re, input int im);
        @(negedge clk);
        rst    = 1'b1;
        di_en  = 1'b1;
        di_sof = 1'b0;
        di_re  = W'(re);
        di_im  = W'(im);
        #1;
        sb.delete();
        model_k = 0;
        chk("rst_do_en", longint'(do_en), 0);
        chk("rst_do_sof", longint'(do_sof), 0);
        chk("rst_do_re", longint'(do_re), 0);
        chk("rst_do_im", longint'(do_im), 0);
        chk("rst_tw_addr", longint'(tw_addr), 0);
        @(negedge clk);
        rst   = 1'b0;
        di_en = 1'b0;
    endtask

    // Monitor: pop and compare on every output; otherwise outputs must hold
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last_re = 0;
                last_im = 0;
            end else if (do_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: do_en=1 re=%0d im=%0d with nothing expected", do_re, do_im);
                end else begin
                    e = sb.pop_front();
                    chk("do_re", longint'(do_re), e.re);
                    chk("do_im", longint'(do_im), e.im);
                    chk("do_sof", longint'(do_sof), e.sof);
                    chk("latency_cycle", longint'(cyc), longint'(e.cyc));
                end
                last_re = longint'(do_re);
                last_im = longint'(do_im);
            end else begin
                chk("hold_re", longint'(do_re), last_re);
                chk("hold_im", longint'(do_im), last_im);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        di_en   = 1'b0;
        di_sof  = 1'b0;
        di_step = '0;
        di_re   = '0;
        di_im   = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_do_en", longint'(do_en), 0);
        chk("reset_do_sof", longint'(do_sof), 0);
        chk("reset_do_re", longint'(do_re), 0);
        chk("reset_do_im", longint'(do_im), 0);
        chk("reset_tw_addr", longint'(tw_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Identity, unit input at step 1 and step 2, saturation
        group(0, 1000, -200);
        idle(3);
        group(1, 1024, 0);
        idle(1);
        group(2, 1024, 0);
        idle(2);
        group(1, 131071, 131071);
        group(5, -131072, -131072);
        group(13, 77777, -55555);
        idle(3);

        // Gap of three idle cycles after k=4
        send(1'b1, 4, 3000, 1500);
        for (int i = 1; i <= 4; i++) send(1'b0, 0, 3000, 1500);
        idle(3);
        for (int i = 5; i < 9; i++) send(1'b0, 0, 3000, 1500);
        idle(2);

        // Restart a group at k=5 with a different step
        send(1'b1, 3, -4000, 2500);
        for (int i = 1; i <= 4; i++) send(1'b0, 1, -4000, 2500);
        group(7, -4000, 2500);
        idle(2);

        // Reset with samples in flight, then a sample without sof restarts at k=0
        send(1'b1, 3, 5000, -6000);
        for (int i = 1; i <= 5; i++) send(1'b0, 2, 5000, -6000);
        reset_mid(5000, -6000);
        idle(2);
        send(1'b0, 5, 500, 300);
        for (int i = 1; i < 9; i++) send(1'b0, 0, 500, 300);
        idle(2);

        // Randomized traffic: gaps, early sof, all step codes, full-range data
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(4, 0) == 0) idle(int'($urandom_range(3, 1)));
            if ($urandom_range(149, 0) == 0) begin
                reset_mid(rnd_data(), rnd_data());
            end
            send(($urandom_range(9, 0) == 0), int'($urandom_range(15, 0)), rnd_data(), rnd_data());
        end

        idle(6);
        chk("scoreboard_empty", longint'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/twiddle9_rotator.md
Name: twiddle9_rotator

Overview:
- Streaming complex twiddle multiplier for the radix-9 stage of the PUSCH DFT.
- Accepts 9-sample groups and drives the 9-entry twiddle ROM address for each sample as (k*step) mod 9.
- Multiplies each sample by the returned Q10 twiddle, then rounds and saturates the product back to 18 bits.
- Sits between the radix-9 butterfly output and the next DFT stage or reorder buffer.

Parameters:
- WIDTH, 18, sample and twiddle word width (two's complement)
- FRAC, 10, twiddle fractional bits (1.0 = 2^FRAC = 1024)

Ports:
- clk  in  1  master clock
- rst  in  1  reset, asynchronous, active-high
- di_en  in  1  input sample valid
- di_sof  in  1  first sample of a 9-sample group; qualified by di_en
- di_step  in  4  rotation step 0..8; sampled with the first sample of each group
- di_re  in  WIDTH  input real
- di_im  in  WIDTH  input imag
- tw_addr  out  4  twiddle ROM address (combinational ROM, no output register)
- tw_re  in  WIDTH  twiddle real returned for tw_addr in the same cycle
- tw_im  in  WIDTH  twiddle imag returned for tw_addr in the same cycle
- do_en  out  1  output valid
- do_sof  out  1  output first-of-group marker
- do_re  out  WIDTH  rotated real
- do_im  out  WIDTH  rotated imag

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: k=0, acc=0, step_q=0, tw_addr=0, do_en=0, do_sof=0, do_re=0, do_im=0, and all pipeline valids cleared.
- Group counter k (0..8):
  - Advances only on di_en.
  - Wraps 8->0.
  - di_en&&di_sof forces the current sample to k=0, even mid-group. The partial group is abandoned, with no error flag.
- Address accumulator:
  - At k=0 the sample uses addr 0 and di_step is latched into step_q. Values above 8 are clamped to 8.
  - Each subsequent accepted sample uses addr = (previous addr + step_q) mod 9, computed with a compare/subtract. No multiplier is used.
  - tw_addr is combinational from the accumulator state and the current di_en/di_sof.
- Gaps: when di_en=0, k and acc hold; samples may arrive with arbitrary gaps. There is no backpressure, so the block must accept one sample per cycle.
- Pipeline, latency 2 cycles from di_en to do_en:
  - Stage 1 registers the four products di_re*tw_re, di_im*tw_im, di_re*tw_im and di_im*tw_re (2*WIDTH bits each), plus valid and sof.
  - Stage 2 computes re = ac-bd and im = ad+bc at 2*WIDTH+1 bits.
  - Stage 2 then adds 2^(FRAC-1), arithmetic-shifts right by FRAC, and saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Exactness: addr 0 (1024+j0) must return the input unchanged; rounding guarantees this.
- do_sof=1 only on the output of a k=0 sample.
- Output when idle: do_re/do_im hold their last value when do_en=0.
- Reset mid-operation: the pipeline is flushed and do_en drops immediately. The next accepted sample is treated as k=0 regardless of di_sof.

Decomposition:
- Shared FFT package holds:
  - WIDTH and FRAC
  - the radix constant 9
  - a round_sat function (value, shift, width) shared with other twiddle multipliers
- One natural sub-module, cmul_q, the 2-stage complex multiply/round/saturate pipeline, reusable for the radix-2/3/5 stages.
- The twiddle ROM is the existing Twiddle9 table, instantiated by the parent with TW_FF=0.

Test Plan:
- Identity: step=0, 9 samples of (1000,-200) back-to-back -> 9 outputs of (1000,-200), first do_en 2 cycles after first di_en, do_sof on the first output only.
- Step 1 on unit input: step=1, di=(1024,0) x9 -> tw_addr 0..8. Output k=1 is (784,-659); output k=3 is (-512, wn_im[3]).
- Step 2 with wrap: step=2, di=(1024,0) -> addr sequence 0,2,4,6,8,1,3,5,7. Output k=1 is (177,-1009).
- Saturation: step=1, k=1, di=(131071,131071) -> do_re=131071 (saturated), do_im=16000.
- Gaps and mid-group sof:
  - di_en low for 3 cycles after k=4 -> addr sequence unchanged and outputs identical to the gapless run.
  - di_sof at k=5 -> that sample uses addr 0 with a new step_q.
- Reset: assert rst at k=6 with 2 samples in flight -> do_en=0 immediately with no stale outputs; the next sample without di_sof produces addr 0 and do_sof=1.
